// File: rtl/seq_calculator.sv
// Multi-cycle unsigned calculator: add/sub in one step, shift-add multiply and
// restoring divide over WIDTH iterations, with a busy/done handshake.
module seq_calculator #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 negative,
  output logic                 div_by_zero
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     result_q, result_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              neg_q, neg_d;
  logic              dbz_q, dbz_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [RW-1:0]     acc_q, acc_d;

  logic [RW-1:0]     prod;
  logic [WIDTH:0]    r_sh;
  logic [WIDTH:0]    r_new;
  logic              qbit;
  logic [WIDTH-1:0]  q_nx;

  function automatic logic [RW-1:0] abs_diff(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return (x >= y) ? RW'(x - y) : RW'(y - x);
  endfunction

  // Multiply: shift_q holds the multiplier (LSB first), mcand_q the shifted multiplicand.
  // Divide: shift_q shifts the dividend out MSB first while quotient bits enter at the LSB.
  assign prod  = acc_q + (shift_q[0] ? mcand_q : '0);
  assign r_sh  = {acc_q[WIDTH-1:0], shift_q[WIDTH-1]};
  assign qbit  = (r_sh >= {1'b0, b_q});
  assign r_new = qbit ? (r_sh - {1'b0, b_q}) : r_sh;
  assign q_nx  = {shift_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    op_d     = op_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          b_d   = b;
          neg_d = 1'b0;
          dbz_d = 1'b0;
          cnt_d = '0;
          unique case (op)
            OP_ADD: begin
              result_d = RW'(a) + RW'(b);
              rem_d    = '0;
              state_d  = DONE;
            end
            OP_SUB: begin
              result_d = abs_diff(a, b);
              rem_d    = '0;
              neg_d    = (a < b);
              state_d  = DONE;
            end
            OP_MUL: begin
              mcand_d = RW'(a);
              shift_d = b;
              acc_d   = '0;
              state_d = RUN;
            end
            default: begin
              if (b == '0) begin
                result_d = '1;
                rem_d    = a;
                dbz_d    = 1'b1;
                state_d  = DONE;
              end else begin
                shift_d = a;
                acc_d   = '0;
                state_d = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d   = prod;
          mcand_d = mcand_q << 1;
          shift_d = shift_q >> 1;
        end else begin
          acc_d   = RW'(r_new);
          shift_d = q_nx;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          if (op_q == OP_MUL) begin
            result_d = prod;
            rem_d    = '0;
          end else begin
            result_d = RW'(q_nx);
            rem_d    = r_new[WIDTH-1:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
    end
  end

  // Working datapath registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    b_q     <= b_d;
    mcand_q <= mcand_d;
    shift_q <= shift_d;
    acc_q   <= acc_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign remainder   = rem_q;
  assign negative    = neg_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_calculator.sv
// Bench for seq_calculator: directed WIDTH=4 cases plus a randomized WIDTH=8 run,
// both checked every cycle against a latency-counter / plain-arithmetic model.
module tb_seq_calculator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, busy4, done4, neg4, dbz4;
  logic [3:0] a4, b4, rem4;
  logic [1:0] op4;
  logic [7:0] res4;

  logic        rst8, start8, busy8, done8, neg8, dbz8;
  logic [7:0]  a8, b8, rem8;
  logic [1:0]  op8;
  logic [15:0] res8;

  seq_calculator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .op(op4), .start(start4),
    .busy(busy4), .done(done4), .result(res4), .remainder(rem4),
    .negative(neg4), .div_by_zero(dbz4));

  seq_calculator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .op(op8), .start(start8),
    .busy(busy8), .done(done8), .result(res8), .remainder(rem8),
    .negative(neg8), .div_by_zero(dbz8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference arithmetic and latency for one operation of width w.
  task automatic compute(input int w, input longint av, input longint bv, input int opv,
                         output longint res, output longint rem, output bit neg,
                         output bit dbz, output int lat);
    res = 0; rem = 0; neg = 0; dbz = 0; lat = 1;
    case (opv)
      0: res = av + bv;
      1: begin
        neg = (av < bv);
        res = neg ? (bv - av) : (av - bv);
      end
      3: begin
        res = av * bv;
        lat = w + 1;
      end
      default: begin
        if (bv == 0) begin
          res = (longint'(1) << (2 * w)) - 1;
          rem = av;
          dbz = 1;
        end else begin
          res = av / bv;
          rem = av % bv;
          lat = w + 1;
        end
      end
    endcase
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic   s_rst[2], s_start[2];
  longint s_a[2], s_b[2];
  int     s_op[2];
  always @(posedge clk) begin
    s_rst[0] <= rst4; s_start[0] <= start4; s_a[0] <= longint'(a4);
    s_b[0] <= longint'(b4); s_op[0] <= int'(op4);
    s_rst[1] <= rst8; s_start[1] <= start8; s_a[1] <= longint'(a8);
    s_b[1] <= longint'(b8); s_op[1] <= int'(op8);
  end

  int     wid[2] = '{4, 8};
  int     left[2];
  longint e_res[2], e_rem[2], p_res[2], p_rem[2];
  bit     e_neg[2], e_dbz[2], p_neg[2], p_dbz[2], mv[2];

  task automatic step(input int i);
    int lat;
    if (s_rst[i] === 1'b1) begin
      left[i] = 0; e_res[i] = 0; e_rem[i] = 0; e_neg[i] = 0; e_dbz[i] = 0; mv[i] = 1;
    end else if (left[i] > 0) begin
      left[i]--;
    end else if (s_start[i] === 1'b1) begin
      compute(wid[i], s_a[i], s_b[i], s_op[i], p_res[i], p_rem[i], p_neg[i], p_dbz[i], lat);
      e_neg[i] = 0; e_dbz[i] = 0;
      left[i] = lat;
    end
    if (s_rst[i] !== 1'b1 && left[i] == 1) begin
      e_res[i] = p_res[i]; e_rem[i] = p_rem[i]; e_neg[i] = p_neg[i]; e_dbz[i] = p_dbz[i];
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      step(0);
      step(1);
      if (mv[0]) begin
        check("w4 busy", 64'(busy4), 64'(left[0] > 0));
        check("w4 done", 64'(done4), 64'(left[0] == 1));
        check("w4 result", 64'(res4), 64'(e_res[0]));
        check("w4 remainder", 64'(rem4), 64'(e_rem[0]));
        check("w4 negative", 64'(neg4), 64'(e_neg[0]));
        check("w4 div_by_zero", 64'(dbz4), 64'(e_dbz[0]));
      end
      if (mv[1]) begin
        check("w8 busy", 64'(busy8), 64'(left[1] > 0));
        check("w8 done", 64'(done8), 64'(left[1] == 1));
        check("w8 result", 64'(res8), 64'(e_res[1]));
        check("w8 remainder", 64'(rem8), 64'(e_rem[1]));
        check("w8 negative", 64'(neg8), 64'(e_neg[1]));
        check("w8 div_by_zero", 64'(dbz8), 64'(e_dbz[1]));
      end
    end
  end

  // Start one W4 op; returns edges from the accepting edge to the first edge sampling done.
  task automatic go4(input int av, input int bv, input int opv, input bit hold, output int lat);
    int k;
    @(posedge clk); #1;
    a4 = 4'(av); b4 = 4'(bv); op4 = 2'(opv); start4 = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a4 = 4'($urandom); b4 = 4'($urandom); op4 = 2'($urandom);
    end else start4 = 1'b0;
    k = 0;
    while (done4 !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    start4 = 1'b0;
    lat = k + 1;
  endtask

  task automatic go8(input int av, input int bv, input int opv, input bit hold, input bit inj);
    int k, lat;
    longint r, m;
    bit n, z;
    @(posedge clk); #1;
    a8 = 8'(av); b8 = 8'(bv); op8 = 2'(opv); start8 = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
    end else start8 = 1'b0;
    if (inj) begin
      start8 = 1'b0; rst8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0;
      check("w8 busy after reset", 64'(busy8), 64'd0);
      return;
    end
    k = 0;
    while (done8 !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    start8 = 1'b0;
    compute(8, longint'(av), longint'(bv), opv, r, m, n, z, lat);
    check("w8 latency", 64'(k + 1), 64'(lat));
    if (opv == 2 && bv != 0)
      check("w8 divide identity", 64'(res8) * 64'(bv) + 64'(rem8), 64'(av));
  endtask

  initial begin
    longint r, m;
    bit n, z;
    int lat;
    rst4 = 1; start4 = 0; a4 = 0; b4 = 0; op4 = 0;
    rst8 = 1; start8 = 0; a8 = 0; b8 = 0; op8 = 0;

    compute(4, 15, 15, 3, r, m, n, z, lat);
    check("model mul 15*15", 64'(r), 64'd225);
    check("model mul latency", 64'(lat), 64'd5);
    compute(4, 9, 0, 2, r, m, n, z, lat);
    check("model div0 result", 64'(r), 64'hFF);
    check("model div0 remainder", 64'(m), 64'd9);
    compute(8, 200, 7, 2, r, m, n, z, lat);
    check("model div 200/7", 64'(r), 64'd28);
    check("model rem 200%7", 64'(m), 64'd4);
    compute(4, 3, 5, 1, r, m, n, z, lat);
    check("model sub 3-5", 64'(r), 64'd2);
    check("model sub negative", 64'(n), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy4), 64'd0);
    check("reset done", 64'(done4), 64'd0);
    check("reset result", 64'(res4), 64'd0);
    check("reset remainder", 64'(rem4), 64'd0);
    check("reset flags", 64'({neg4, dbz4}), 64'd0);
    rst4 = 0; rst8 = 0;

    go4(9, 7, 0, 0, lat);
    check("add latency", 64'(lat), 64'd1);
    check("add 9+7", 64'(res4), 64'h10);
    check("add negative", 64'(neg4), 64'd0);

    go4(3, 5, 1, 0, lat);
    check("sub latency", 64'(lat), 64'd1);
    check("sub 3-5", 64'(res4), 64'd2);
    check("sub 3-5 negative", 64'(neg4), 64'd1);
    go4(5, 5, 1, 0, lat);
    check("sub 5-5", 64'(res4), 64'd0);
    check("sub 5-5 negative", 64'(neg4), 64'd0);

    go4(15, 15, 3, 1, lat);
    check("mul latency", 64'(lat), 64'd5);
    check("mul 15*15", 64'(res4), 64'd225);
    check("mul remainder", 64'(rem4), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mul result held", 64'(res4), 64'd225);
    check("idle after held start", 64'(busy4), 64'd0);

    go4(13, 4, 2, 0, lat);
    check("div latency", 64'(lat), 64'd5);
    check("div 13/4", 64'(res4), 64'd3);
    check("div 13%4", 64'(rem4), 64'd1);
    go4(9, 0, 2, 0, lat);
    check("div0 latency", 64'(lat), 64'd1);
    check("div0 result", 64'(res4), 64'hFF);
    check("div0 remainder", 64'(rem4), 64'd9);
    check("div0 flag", 64'(dbz4), 64'd1);

    @(posedge clk); #1;
    a4 = 7; b4 = 6; op4 = 3; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #1;
    rst4 = 1;
    @(posedge clk); #1;
    rst4 = 0;
    check("abort busy", 64'(busy4), 64'd0);
    check("abort result", 64'(res4), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort no done", 64'(done4), 64'd0);
    end
    go4(7, 6, 0, 0, lat);
    check("add after abort latency", 64'(lat), 64'd1);
    check("add 7+6", 64'(res4), 64'd13);

    @(posedge clk); #1;
    rst4 = 1; start4 = 1; a4 = 3; b4 = 4; op4 = 0;
    @(posedge clk); #1;
    rst4 = 0; start4 = 0;
    check("rst beats start busy", 64'(busy4), 64'd0);
    @(posedge clk); #1;
    check("rst beats start done", 64'(done4), 64'd0);

    for (int t = 0; t < 200; t++) begin
      int av, bv, opv;
      av = int'($urandom_range(0, 255));
      bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      opv = int'($urandom_range(0, 3));
      go8(av, bv, opv, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    start8 = 1;
    for (int t = 0; t < 80; t++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      op8 = 2'($urandom);
      @(posedge clk); #1;
    end
    start8 = 0;
    for (int t = 0; t < 12 && busy8 === 1'b1; t++) begin
      @(posedge clk); #1;
    end
    check("w8 idle after stream", 64'(busy8), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
Parametrised, multi-cycle successor to the switch-driven calculator datapath. It accepts two WIDTH-bit unsigned operands and an opcode on a start pulse. It computes add, subtract, multiply (shift-add) or divide (restoring) through one shared FSM and returns a registered result with a busy/done handshake. It sits between the operand/opcode source (switches or keypad decoder) and the binary-to-BCD / seven-segment display path.

Parameters:
WIDTH, 4, operand width in bits (legal 2..16); result width is 2*WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
a  input  WIDTH  operand A (dividend / minuend), unsigned
b  input  WIDTH  operand B (divisor / subtrahend), unsigned
op  input  2  opcode: 00 add, 01 subtract, 10 divide, 11 multiply
start  input  1  request; accepted only when busy=0
busy  output  1  high while an operation is in flight (states RUN, DONE)
done  output  1  one-cycle pulse; result fields valid from this cycle onward
result  output  2*WIDTH  sum / |difference| / quotient (zero-extended) / product
remainder  output  WIDTH  division remainder; 0 for other ops
negative  output  1  subtract only: 1 when a < b
div_by_zero  output  1  divide only: 1 when b == 0

Behaviour:
- Reset is synchronous and active-high. At any edge with rst=1: state=IDLE, busy=0, done=0, result=0, remainder=0, negative=0, div_by_zero=0, iteration counter=0. This applies mid-operation too; the in-flight op is discarded and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 sampled at edge N latches a, b and op into internal registers. The live inputs are ignored after that edge. Flags negative and div_by_zero clear at edge N.
  - add/sub, or divide with b==0: compute in one step, go to DONE at edge N.
  - mul, or divide with b!=0: go to RUN at edge N with counter=0.
- RUN: one iteration per clock. Counter increments and RUN exits to DONE on the edge that completes iteration WIDTH-1, so there are exactly WIDTH iterations.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Latency (edges from start-sampling edge N to the first edge sampling done=1): add/sub/div-by-zero = 1 (edge N+1); mul/div = WIDTH+1 (edge N+WIDTH+1).
- busy=1 in RUN and DONE. start while busy=1 is ignored: not queued, no effect on latched operands.
- Add: result = a + b, zero-extended. Carry lands in bit WIDTH; no overflow is possible.
- Subtract: result = |a - b| zero-extended; negative = (a < b). a == b gives result 0, negative 0.
- Multiply: shift-add over WIDTH iterations, LSB of multiplier first. Accumulator is 2*WIDTH bits. result = a*b exactly; remainder = 0.
- Divide (b != 0): restoring division, MSB first, WIDTH iterations. result = a / b zero-extended; remainder = a % b.
- Divide (b == 0): result = all ones (2*WIDTH bits), remainder = a, div_by_zero = 1.
- result, remainder and flags update only in the cycle entering DONE, or at reset. They hold stable through IDLE until the next accepted start. Intermediate accumulators are internal and never visible on result.
- start and rst asserted on the same edge: rst wins and start is dropped.
- start held high continuously: a new op is accepted on the first edge in IDLE after each DONE, giving back-to-back operation with a one-cycle IDLE gap.

Test Plan:
- WIDTH=4, rst for 2 cycles -> all outputs 0, busy=0. Then a=9, b=7, op=00, start 1 cycle -> done at edge N+1, result=16 (0x10), negative=0.
- a=3, b=5, op=01 -> done at N+1, result=2, negative=1. Then a=5, b=5 -> result=0, negative=0.
- a=15, b=15, op=11 -> busy for 5 cycles, done sampled at edge N+5, result=225 (0xE1), remainder=0. Hold start high while busy -> no second op; result stable.
- a=13, b=4, op=10 -> done at N+5, result=3, remainder=1. Then a=9, b=0, op=10 -> done at N+1, result=0xFF, remainder=9, div_by_zero=1.
- Start mul a=7, b=6; assert rst at edge N+2 -> state IDLE, busy=0, result=0, no done pulse. Next op (7+6) -> result=13 at N'+1.
- WIDTH=8 sweep: random a, b for all ops against a reference model; mul/div latency = 9; divide identity a == q*b + r holds for b != 0.
